// File: rtl/rata_pkg.sv
// Shared definitions for the LMT writer: FSM state encoding, word count and default base.
// RATA_LMT_SEQ_EN selects the 8-word layout (timestamp + sequence number); otherwise 4 words.
package rata_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNAP  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } lmt_state_e;

`ifdef RATA_LMT_SEQ_EN
    localparam int LMT_WORDS = 8;
`else
    localparam int LMT_WORDS = 4;
`endif

    localparam int          LMT_IDX_W        = $clog2(LMT_WORDS);
    localparam logic [15:0] LMT_BASE_DEFAULT = 16'h000A;

    // Word index to byte address: each LMT word occupies two bytes.
    function automatic logic [15:0] lmt_word_addr(input logic [15:0]          base,
                                                   input logic [LMT_IDX_W-1:0] idx);
        return base + {{(15 - LMT_IDX_W){1'b0}}, idx, 1'b0};
    endfunction

endpackage

// File: rtl/rata_time_counter.sv
// Free-running 64-bit timestamp advanced once every TICK_DIV clock cycles; wraps to zero.
module rata_time_counter #(
    parameter logic [15:0] TICK_DIV = 16'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] lmt_time_o
);

    logic [15:0] pre_q, pre_d;
    logic [63:0] cnt_q, cnt_d;
    logic        tick;

    // The >= compare keeps the prescaler bounded even for an out-of-range divider.
    always_comb begin
        tick  = (pre_q >= (TICK_DIV - 16'd1));
        pre_d = tick ? 16'd0 : pre_q + 16'd1;
        cnt_d = tick ? cnt_q + 64'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= 16'd0;
            cnt_q <= 64'd0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    assign lmt_time_o = cnt_q;

endmodule

// File: rtl/rata_lmt_writer.sv
// Snapshots the timestamp on each attestation-region update and writes it word by word into the LMT.
// RATA_LMT_SEQ_EN adds a 64-bit sequence number written after the timestamp.
module rata_lmt_writer
    import rata_pkg::*;
#(
    parameter logic [15:0] LMT_BASE = LMT_BASE_DEFAULT,
    parameter logic [15:0] TICK_DIV = 16'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upLMT,
    output logic        lmt_wr_req,
    input  logic        lmt_wr_gnt,
    output logic [15:0] lmt_wr_addr,
    output logic [15:0] lmt_wr_data,
    output logic        lmt_busy,
    output logic [63:0] lmt_time
);

    localparam logic [LMT_IDX_W-1:0] LAST_IDX = LMT_IDX_W'(LMT_WORDS - 1);

    lmt_state_e                 state_q, state_d;
    logic                       uplmt_q;
    logic                       pend_q, pend_d;
    logic [LMT_IDX_W-1:0]       idx_q, idx_d;
    logic [63:0]                snap_q, snap_d;
    logic [16*LMT_WORDS-1:0]    payload;
    logic                       event_w;

    rata_time_counter #(
        .TICK_DIV (TICK_DIV)
    ) u_time (
        .clk        (clk),
        .rst_n      (rst_n),
        .lmt_time_o (lmt_time)
    );

    assign event_w = upLMT & ~uplmt_q;

`ifdef RATA_LMT_SEQ_EN
    logic [63:0] seq_q, seq_d;

    always_comb begin
        seq_d = seq_q;
        if (state_q == ST_SNAP) begin
            seq_d = seq_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= 64'd0;
        end else begin
            seq_q <= seq_d;
        end
    end

    assign payload = {seq_q, snap_q};
`else
    assign payload = snap_q;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (event_w || pend_q) state_d = ST_SNAP;
            ST_SNAP:  state_d = ST_WRITE;
            ST_WRITE: if (lmt_wr_gnt && (idx_q == LAST_IDX)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Events arriving while busy coalesce into one pending update; time is sampled later in SNAP.
    always_comb begin
        pend_d = pend_q;
        idx_d  = idx_q;
        snap_d = snap_q;
        if ((state_q == ST_IDLE) && (event_w || pend_q)) begin
            pend_d = 1'b0;
        end else if (event_w) begin
            pend_d = 1'b1;
        end
        if (state_q == ST_SNAP) begin
            snap_d = lmt_time;
            idx_d  = '0;
        end else if ((state_q == ST_WRITE) && lmt_wr_gnt) begin
            idx_d = idx_q + LMT_IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uplmt_q <= 1'b0;
            pend_q  <= 1'b0;
            idx_q   <= '0;
            snap_q  <= 64'd0;
        end else begin
            uplmt_q <= upLMT;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

    // Outputs decode the state register only, so an asynchronous reset drops the request at once.
    always_comb begin
        lmt_wr_req  = (state_q == ST_WRITE);
        lmt_busy    = (state_q != ST_IDLE);
        lmt_wr_addr = lmt_word_addr(LMT_BASE, idx_q);
        lmt_wr_data = payload[{idx_q, 4'b0000} +: 16];
    end

endmodule

// File: tb/tb_rata_lmt_writer.sv
// Bench for rata_lmt_writer: per-cycle vector table for one update plus sequences for stall,
// coalescing, coincident event, wrap and reset cases; writes are checked against an expected queue.
module tb_rata_lmt_writer;
    import rata_pkg::*;

    localparam logic [15:0] BASE = 16'h000A;
    localparam int          NV   = LMT_WORDS + 4;

    typedef struct {
        logic        up;
        logic        gnt;
        logic        exp_req;
        logic        exp_busy;
        logic [15:0] exp_addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        upLMT = 1'b0;
    logic        lmt_wr_gnt = 1'b1;
    logic        lmt_wr_req;
    logic [15:0] lmt_wr_addr;
    logic [15:0] lmt_wr_data;
    logic        lmt_busy;
    logic [63:0] lmt_time;

    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_upd = 0;
    logic [63:0] mt;
    logic        preset_pend = 1'b0;
    logic [63:0] preset_val = 64'd0;
    vec_t        tbl[NV];

    rata_lmt_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .upLMT       (upLMT),
        .lmt_wr_req  (lmt_wr_req),
        .lmt_wr_gnt  (lmt_wr_gnt),
        .lmt_wr_addr (lmt_wr_addr),
        .lmt_wr_data (lmt_wr_data),
        .lmt_busy    (lmt_busy),
        .lmt_time    (lmt_time)
    );

    // Clock and reference timestamp
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mt <= 64'd0;
        else if (preset_pend) mt <= preset_val + 64'd1;
        else mt <= mt + 64'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp_v);
        end
    endtask

    task automatic push_update(input logic [63:0] t);
        logic [63:0] seq;
        logic [15:0] d;
        n_upd++;
        seq = 64'(n_upd);
        for (int w = 0; w < LMT_WORDS; w++) begin
            if (w < 4) d = t[16*w +: 16];
            else d = seq[16*(w-4) +: 16];
            exp_q.push_back({BASE + 16'(2*w), d});
        end
    endtask

    task automatic monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && lmt_wr_req && lmt_wr_gnt) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: actual addr=%h data=%h required no write",
                             lmt_wr_addr, lmt_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 64'(lmt_wr_addr), 64'(e[31:16]));
                    check("write_data", 64'(lmt_wr_data), 64'(e[15:0]));
                end
            end
        end
    endtask

    // Driver: advance to the next falling edge and apply inputs
    task automatic cyc(input logic up, input logic g);
        @(negedge clk);
        upLMT      = up;
        lmt_wr_gnt = g;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b1);
        #1;
        check("idle_busy", 64'(lmt_busy), 64'd0);
    endtask

    initial begin
        logic [63:0] t_e;
        logic [15:0] d_stall;
        int          bad;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
        for (int w = 0; w < LMT_WORDS; w++)
            tbl[2+w] = '{1'b0, 1'b1, 1'b1, 1'b1, BASE + 16'(2*w)};
        tbl[NV-2] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[NV-1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};

        rst_n = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_req", 64'(lmt_wr_req), 64'd0);
        check("reset_busy", 64'(lmt_busy), 64'd0);
        check("reset_time", lmt_time, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b1);
        #1;
        check("time_count", lmt_time, 64'd3);
        repeat (5) cyc(1'b0, 1'b1);

        // Single update, per-cycle table
        for (int i = 0; i < NV; i++) begin
            cyc(tbl[i].up, tbl[i].gnt);
            #1;
            if (i == 0) push_update(mt + 64'd1);
            check("vec_req", 64'(lmt_wr_req), 64'(tbl[i].exp_req));
            check("vec_busy", 64'(lmt_busy), 64'(tbl[i].exp_busy));
            if (tbl[i].exp_req) check("vec_addr", 64'(lmt_wr_addr), 64'(tbl[i].exp_addr));
            check("vec_time", lmt_time, mt);
        end
        idle(3);

        // Grant held low for five cycles on word 1
        cyc(1'b1, 1'b1);
        #1;
        t_e = mt + 64'd1;
        push_update(t_e);
        d_stall = t_e[31:16];
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc(1'b0, 1'b0);
            #1;
            check("stall_addr", 64'(lmt_wr_addr), 64'(BASE + 16'd2));
            check("stall_data", 64'(lmt_wr_data), 64'(d_stall));
        end
        idle(LMT_WORDS + 4);

        // Three events while busy coalesce into one follow-up update
        cyc(1'b1, 1'b1);
        #1;
        t_e = mt;
        push_update(t_e + 64'd1);
        for (int c = 1; c <= 6; c++) cyc(c % 2 == 0, 1'b0);
        push_update(t_e + 64'(9 + LMT_WORDS));
        idle(2 * LMT_WORDS + 8);
        check("pending_once", 64'(exp_q.size()), 64'd0);

        // Event coincident with the last-word grant
        cyc(1'b1, 1'b1);
        #1;
        t_e = mt;
        push_update(t_e + 64'd1);
        for (int k = 1; k <= LMT_WORDS + 1; k++) cyc(k == LMT_WORDS + 1, 1'b1);
        push_update(t_e + 64'(4 + LMT_WORDS));
        cyc(1'b0, 1'b1);
        #1;
        check("coinc_done_busy", 64'(lmt_busy), 64'd1);
        cyc(1'b0, 1'b1);
        #1;
        check("coinc_idle_busy", 64'(lmt_busy), 64'd0);
        cyc(1'b0, 1'b1);
        #1;
        check("coinc_snap_busy", 64'(lmt_busy), 64'd1);
        idle(LMT_WORDS + 6);

        // Timestamp wrap; snapshot taken in the zero cycle
        @(negedge clk);
        preset_val  = 64'hFFFF_FFFF_FFFF_FFFE;
        preset_pend = 1'b1;
        dut.u_time.cnt_q <= 64'hFFFF_FFFF_FFFF_FFFE;
        @(posedge clk);
        #1;
        preset_pend = 1'b0;
        cyc(1'b1, 1'b1);
        #1;
        check("wrap_ones", lmt_time, 64'hFFFF_FFFF_FFFF_FFFF);
        push_update(mt + 64'd1);
        cyc(1'b0, 1'b1);
        #1;
        check("wrap_zero", lmt_time, 64'd0);
        idle(LMT_WORDS + 5);

        // Reset asserted while word 2 is presented
        cyc(1'b1, 1'b1);
        #1;
        push_update(mt + 64'd1);
        repeat (4) cyc(1'b0, 1'b1);
        #1;
        check("rst_word2_addr", 64'(lmt_wr_addr), 64'(BASE + 16'd4));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req_drop", 64'(lmt_wr_req), 64'd0);
        check("rst_busy_drop", 64'(lmt_busy), 64'd0);
        check("rst_time_zero", lmt_time, 64'd0);
        exp_q.delete();
        n_upd = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (12) begin
            cyc(1'b0, 1'b1);
            #1;
            if (lmt_wr_req) bad++;
        end
        check("no_resume", 64'(bad), 64'd0);

        // upLMT high at reset release counts as an event
        @(negedge clk);
        rst_n = 1'b0;
        upLMT = 1'b1;
        n_upd = 0;
        @(negedge clk);
        rst_n = 1'b1;
        push_update(mt + 64'd1);
        #1;
        check("release_idle", 64'(lmt_busy), 64'd0);
        cyc(1'b1, 1'b1);
        #1;
        check("release_snap", 64'(lmt_busy), 64'd1);
        idle(LMT_WORDS + 5);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rata_lmt_writer.md
RATA_LMT_WRITER -- requirements
Module: rata_lmt_writer

Interface
REQ-001 Parameter LMT_BASE, default 16'h000A, byte address of LMT word 0.
REQ-002 Parameter TICK_DIV, default 16'd1, clk cycles per timestamp increment (>=1).
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 upLMT  input  1  level from the attestation-region monitor; high while the region is being modified.
REQ-006 lmt_wr_req  output  1  word-write request to the LMT memory port.
REQ-007 lmt_wr_gnt  input  1  port accepts the presented word this cycle.
REQ-008 lmt_wr_addr  output  16  byte address of the presented word.
REQ-009 lmt_wr_data  output  16  data of the presented word.
REQ-010 lmt_busy  output  1  high while an LMT update is in progress; the monitor uses it to exempt these writes from kill detection.
REQ-011 lmt_time  output  64  live timestamp counter value.

Function
REQ-012 Timestamp: 64-bit counter that increments once every TICK_DIV clk cycles and wraps from all-ones to 0.
REQ-013 Event: a rising edge of upLMT (registered previous value 0, current value 1) is an update event.
REQ-014 FSM states: IDLE, SNAP, WRITE, DONE.
REQ-015 IDLE -> SNAP on an event or when the pending flag is set; the pending flag clears on that transition.
REQ-016 SNAP (1 cycle): latch lmt_time into the 64-bit snapshot; increment the sequence number (feature-dependent); move to WRITE with word index 0.
REQ-017 WRITE: lmt_wr_req=1, lmt_wr_addr=LMT_BASE+2*index, lmt_wr_data=snapshot word[index], least-significant 16 bits first.
REQ-018 While lmt_wr_req=1 and lmt_wr_gnt=0, addr and data remain stable; there is no timeout.
REQ-019 Each cycle with lmt_wr_req=1 and lmt_wr_gnt=1 advances the index; the grant of the last word moves the FSM to DONE.
REQ-020 DONE (1 cycle) -> IDLE; lmt_wr_req=0.
REQ-021 lmt_busy=1 in SNAP, WRITE and DONE; 0 in IDLE.
REQ-022 An event in SNAP/WRITE/DONE sets the pending flag; multiple events coalesce into one; the pending update snapshots time when it enters SNAP, not at event time.
REQ-023 An event coincident with the last-word grant sets pending; the next SNAP follows DONE->IDLE with no extra delay.
REQ-024 Latency: from an event in IDLE with gnt tied high, the first word is presented 2 cycles later (event registered, then SNAP), and one word is written per cycle after that.

Reset
REQ-025 rst_n low asynchronously clears the FSM to IDLE, pending, index, snapshot, sequence number, prescaler and lmt_time to 0, and drives lmt_wr_req=0 and lmt_busy=0.
REQ-026 Reset mid-WRITE aborts the update; words already granted are not rewritten, and no write resumes after reset.
REQ-027 The registered upLMT value resets to 0, so a upLMT level that is high at reset release counts as an event.

Configuration
REQ-028 Macro RATA_LMT_SEQ_EN defined: a 64-bit sequence number, incremented in SNAP and wrapping at 2^64, is written as words 4-7 after the timestamp (8 words in total).
REQ-029 RATA_LMT_SEQ_EN undefined: no sequence register is built; only words 0-3 are written, and LMT_BASE+8..+14 are never addressed.

Structure
REQ-030 Shared package rata_pkg holds the FSM state enum, LMT_WORDS (4 or 8, selected by the macro) and the default LMT_BASE.
REQ-031 Sub-module rata_time_counter contains the TICK_DIV prescaler and the 64-bit counter, and drives lmt_time.

Verification
REQ-032 TICK_DIV=1, gnt=1, upLMT 0->1 at cycle 10 -> SNAP at cycle 11, writes to 0x000A,0x000C,0x000E,0x0010 on cycles 12-15 carrying the snapshot, lmt_busy high for cycles 11-16.
REQ-033 gnt held low for 5 cycles on word 1 -> addr 0x000C and data stable throughout the stall, no word skipped or duplicated.
REQ-034 Three upLMT pulses during WRITE -> exactly one additional update after DONE, whose snapshot is later than the first.
REQ-035 lmt_time preset near 64'hFFFF_FFFF_FFFF_FFFE with TICK_DIV=1 -> wraps to 0; a snapshot taken after the wrap writes 0x0000 to all timestamp words.
REQ-036 rst_n low during word 2 -> lmt_wr_req drops immediately (asynchronously), no further writes, lmt_time=0.
REQ-037 RATA_LMT_SEQ_EN defined, two updates -> words 4-7 carry sequence 1 then 2; macro undefined -> only 4 writes per update.
